// File: rtl/sp_ram_arbiter.sv
// Round-robin arbiter sharing one single-port RAM among NUM_REQ requesters.
// Grant is combinational; every grant gets a one-cycle-later rvalid pulse carrying the RAM read data.
module sp_ram_arbiter #(
   parameter int NUM_REQ    = 2,
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic [NUM_REQ-1:0]                req_i,
   input  logic [NUM_REQ-1:0]                we_i,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]     addr_i,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]     wdata_i,
   input  logic [NUM_REQ*DATA_WIDTH/8-1:0]   be_i,
   output logic [NUM_REQ-1:0]                gnt_o,
   output logic [NUM_REQ-1:0]                rvalid_o,
   output logic [DATA_WIDTH-1:0]             rdata_o,
   output logic                              ram_en_o,
   output logic                              ram_we_o,
   output logic [ADDR_WIDTH-1:0]             ram_addr_o,
   output logic [DATA_WIDTH-1:0]             ram_wdata_o,
   output logic [DATA_WIDTH/8-1:0]           ram_be_o,
   input  logic [DATA_WIDTH-1:0]             ram_rdata_i
);

   localparam int PTR_W = $clog2(NUM_REQ);
   localparam int BE_W  = DATA_WIDTH / 8;

   logic [PTR_W-1:0] ptr_q, ptr_d;
   logic             rsp_vld_q, rsp_vld_d;
   logic [PTR_W-1:0] rsp_id_q, rsp_id_d;

   logic             found;
   logic [PTR_W-1:0] win;
   logic [PTR_W-1:0] cand;
   int               idx;

   // Search order starts at ptr and wraps; reset suppresses any grant.
   always_comb begin
      found = 1'b0;
      win   = '0;
      cand  = '0;
      idx   = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = int'(ptr_q) + i;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         cand = PTR_W'(idx);
         if (!found && req_i[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end
      if (!rst_n) found = 1'b0;
   end

   always_comb begin
      gnt_o       = '0;
      ram_en_o    = 1'b0;
      ram_we_o    = 1'b0;
      ram_addr_o  = '0;
      ram_wdata_o = '0;
      ram_be_o    = '0;
      if (found) begin
         gnt_o[win]  = 1'b1;
         ram_en_o    = 1'b1;
         ram_we_o    = we_i[win];
         ram_addr_o  = addr_i[win*ADDR_WIDTH +: ADDR_WIDTH];
         ram_wdata_o = wdata_i[win*DATA_WIDTH +: DATA_WIDTH];
         ram_be_o    = be_i[win*BE_W +: BE_W];
      end
   end

   always_comb begin
      ptr_d     = ptr_q;
      rsp_vld_d = found;
      rsp_id_d  = rsp_id_q;
      if (found) begin
         ptr_d    = (win == PTR_W'(NUM_REQ - 1)) ? '0 : win + PTR_W'(1);
         rsp_id_d = win;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q     <= '0;
         rsp_vld_q <= 1'b0;
         rsp_id_q  <= '0;
      end else begin
         ptr_q     <= ptr_d;
         rsp_vld_q <= rsp_vld_d;
         rsp_id_q  <= rsp_id_d;
      end
   end

   always_comb begin
      rvalid_o = '0;
      if (rsp_vld_q) rvalid_o[rsp_id_q] = 1'b1;
   end

   assign rdata_o = ram_rdata_i;

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// Directed bench for sp_ram_arbiter with an attached byte-enabled, read-before-write RAM model.
module tb_sp_ram_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  req, we;
   logic [15:0] addr;
   logic [63:0] wdata;
   logic [7:0]  be;
   logic [1:0]  gnt, rvalid;
   logic [31:0] rdata;
   logic        ram_en, ram_we;
   logic [7:0]  ram_addr;
   logic [31:0] ram_wdata;
   logic [3:0]  ram_be;
   logic [31:0] ram_rdata;

   logic [31:0] mem [256];
   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   sp_ram_arbiter #(.NUM_REQ(2), .ADDR_WIDTH(8), .DATA_WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata), .be_i(be),
      .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata),
      .ram_en_o(ram_en), .ram_we_o(ram_we), .ram_addr_o(ram_addr),
      .ram_wdata_o(ram_wdata), .ram_be_o(ram_be), .ram_rdata_i(ram_rdata)
   );

   // RAM model: registered read of the pre-write word, byte-enabled write. Contents preset to A50000xx.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ram_rdata <= '0;
         for (int i = 0; i < 256; i++) mem[i] <= 32'hA500_0000 | 32'(i);
      end else if (ram_en) begin
         ram_rdata <= mem[ram_addr];
         if (ram_we)
            for (int b = 0; b < 4; b++)
               if (ram_be[b]) mem[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [1:0] r, input logic [1:0] w,
                        input logic [7:0] a0, input logic [7:0] a1,
                        input logic [31:0] d0, input logic [31:0] d1,
                        input logic [3:0] b0, input logic [3:0] b1);
      req   = r;
      we    = w;
      addr  = {a1, a0};
      wdata = {d1, d0};
      be    = {b1, b0};
   endtask

   task automatic cyc;
      @(negedge clk);
   endtask

   initial begin
      logic [1:0] exp_g, prev_g;
      int n0, n1;

      rst_n = 1'b0;
      drive(2'b11, 2'b00, 8'h30, 8'h40, 32'h0, 32'h0, 4'hF, 4'hF);
      cyc(); #1;
      chk("reset_gnt", 64'(gnt), 64'h0);
      chk("reset_en", 64'(ram_en), 64'h0);
      chk("reset_rvalid", 64'(rvalid), 64'h0);
      cyc();

      // Single write then read
      rst_n = 1'b1;
      drive(2'b00, 2'b00, 8'h00, 8'h00, 32'h0, 32'h0, 4'h0, 4'h0);
      #1 chk("post_release_rvalid", 64'(rvalid), 64'h0);
      cyc();
      drive(2'b01, 2'b01, 8'h10, 8'h00, 32'hDEAD_BEEF, 32'h0, 4'hF, 4'h0);
      #1;
      chk("wr_gnt", 64'(gnt), 64'h1);
      chk("wr_en", 64'(ram_en), 64'h1);
      chk("wr_we", 64'(ram_we), 64'h1);
      chk("wr_addr", 64'(ram_addr), 64'h10);
      chk("wr_wdata", 64'(ram_wdata), 64'hDEAD_BEEF);
      chk("wr_be", 64'(ram_be), 64'hF);
      cyc();
      drive(2'b01, 2'b00, 8'h10, 8'h00, 32'h0, 32'h0, 4'hF, 4'h0);
      #1;
      chk("rd_gnt", 64'(gnt), 64'h1);
      chk("rd_we", 64'(ram_we), 64'h0);
      chk("wr_rvalid", 64'(rvalid), 64'h1);
      chk("wr_rdata_prewrite", 64'(rdata), 64'hA500_0010);
      cyc();
      drive(2'b00, 2'b00, 8'h00, 8'h00, 32'h0, 32'h0, 4'h0, 4'h0);
      #1;
      chk("rd_rvalid", 64'(rvalid), 64'h1);
      chk("rd_rdata", 64'(rdata), 64'hDEAD_BEEF);
      chk("idle_en", 64'(ram_en), 64'h0);
      chk("idle_addr", 64'(ram_addr), 64'h0);
      chk("idle_gnt", 64'(gnt), 64'h0);

      // Contention after reset (ptr was 1 before this reset)
      cyc();
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
      drive(2'b11, 2'b00, 8'h30, 8'h40, 32'h0, 32'h0, 4'hF, 4'hF);
      #1;
      chk("cont_gnt0", 64'(gnt), 64'h1);
      chk("cont_addr0", 64'(ram_addr), 64'h30);
      chk("cont_rvalid_first", 64'(rvalid), 64'h0);
      cyc();
      drive(2'b10, 2'b00, 8'h30, 8'h40, 32'h0, 32'h0, 4'hF, 4'hF);
      #1;
      chk("cont_gnt1", 64'(gnt), 64'h2);
      chk("cont_addr1", 64'(ram_addr), 64'h40);
      chk("cont_rvalid0", 64'(rvalid), 64'h1);
      chk("cont_rdata0", 64'(rdata), 64'hA500_0030);

      // Continuous contention for 8 cycles
      prev_g = 2'b10;
      n0 = 0;
      n1 = 0;
      for (int i = 0; i < 8; i++) begin
         cyc();
         drive(2'b11, 2'b00, 8'h30, 8'h40, 32'h0, 32'h0, 4'hF, 4'hF);
         #1;
         exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
         chk($sformatf("rr_gnt_%0d", i), 64'(gnt), 64'(exp_g));
         chk($sformatf("rr_rvalid_%0d", i), 64'(rvalid), 64'(prev_g));
         chk($sformatf("rr_rdata_%0d", i), 64'(rdata),
             (prev_g == 2'b01) ? 64'hA500_0030 : 64'hA500_0040);
         if (gnt == 2'b01) n0++;
         if (gnt == 2'b10) n1++;
         prev_g = exp_g;
      end
      chk("rr_count0", 64'(n0), 64'd4);
      chk("rr_count1", 64'(n1), 64'd4);

      // Byte enables
      cyc();
      drive(2'b01, 2'b01, 8'h20, 8'h00, 32'h1122_3344, 32'h0, 4'hF, 4'h0);
      #1;
      chk("be_w1_gnt", 64'(gnt), 64'h1);
      chk("be_w1_rvalid", 64'(rvalid), 64'h2);
      cyc();
      drive(2'b01, 2'b01, 8'h20, 8'h00, 32'hAABB_CCDD, 32'h0, 4'b0101, 4'h0);
      #1;
      chk("be_w2_be", 64'(ram_be), 64'h5);
      chk("be_w2_wdata", 64'(ram_wdata), 64'hAABB_CCDD);
      cyc();
      drive(2'b01, 2'b00, 8'h20, 8'h00, 32'h0, 32'h0, 4'hF, 4'h0);
      #1 chk("be_rd_gnt", 64'(gnt), 64'h1);
      cyc();
      drive(2'b00, 2'b00, 8'h00, 8'h00, 32'h0, 32'h0, 4'h0, 4'h0);
      #1;
      chk("be_rd_rvalid", 64'(rvalid), 64'h1);
      chk("be_rd_rdata", 64'(rdata), 64'h11BB_33DD);

      // Idle and pointer hold
      cyc();
      drive(2'b10, 2'b00, 8'h00, 8'h40, 32'h0, 32'h0, 4'h0, 4'hF);
      #1 chk("hold_gnt1", 64'(gnt), 64'h2);
      cyc();
      drive(2'b00, 2'b00, 8'h00, 8'h00, 32'h0, 32'h0, 4'h0, 4'h0);
      #1;
      chk("hold_idle1_en", 64'(ram_en), 64'h0);
      chk("hold_rvalid1", 64'(rvalid), 64'h2);
      chk("hold_rdata1", 64'(rdata), 64'hA500_0040);
      cyc();
      #1;
      chk("hold_idle2_en", 64'(ram_en), 64'h0);
      chk("hold_idle2_rvalid", 64'(rvalid), 64'h0);
      cyc();
      drive(2'b11, 2'b00, 8'h30, 8'h40, 32'h0, 32'h0, 4'hF, 4'hF);
      #1 chk("hold_gnt_after_idle", 64'(gnt), 64'h1);

      // Reset mid-operation
      cyc();
      drive(2'b10, 2'b00, 8'h30, 8'h40, 32'h0, 32'h0, 4'hF, 4'hF);
      #1 chk("mid_gnt1", 64'(gnt), 64'h2);
      cyc();
      drive(2'b11, 2'b00, 8'h30, 8'h40, 32'h0, 32'h0, 4'hF, 4'hF);
      #1 chk("mid_rvalid_before_rst", 64'(rvalid), 64'h2);
      rst_n = 1'b0;
      #1;
      chk("mid_rvalid_in_rst", 64'(rvalid), 64'h0);
      chk("mid_gnt_in_rst", 64'(gnt), 64'h0);
      chk("mid_en_in_rst", 64'(ram_en), 64'h0);
      cyc();
      #1;
      chk("mid_gnt_in_rst2", 64'(gnt), 64'h0);
      chk("mid_rvalid_in_rst2", 64'(rvalid), 64'h0);
      cyc();
      rst_n = 1'b1;
      #1;
      chk("mid_release_gnt0", 64'(gnt), 64'h1);
      chk("mid_release_rvalid", 64'(rvalid), 64'h0);
      cyc();
      drive(2'b10, 2'b00, 8'h30, 8'h40, 32'h0, 32'h0, 4'hF, 4'hF);
      #1;
      chk("mid_gnt1_after", 64'(gnt), 64'h2);
      chk("mid_rvalid0_after", 64'(rvalid), 64'h1);
      chk("mid_rdata0_after", 64'(rdata), 64'hA500_0030);
      cyc();
      drive(2'b00, 2'b00, 8'h00, 8'h00, 32'h0, 32'h0, 4'h0, 4'h0);
      #1;
      chk("mid_rvalid1_after", 64'(rvalid), 64'h2);
      chk("mid_rdata1_after", 64'(rdata), 64'hA500_0040);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
